game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 48 ++++
 rtl/game_sequencer_if.sv | 13 +
 rtl/game_sequencer_frame_ticker.sv | 60 ++++++
 rtl/game_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the game sequencer: state encoding,
// datapath step codes and the default frame period.
package game_sequencer_pkg;

  localparam int unsigned FRAME_TICKS_DEFAULT = 833333;
  localparam int          TICK_W              = 20;
  localparam int          STEP_OP_W           = 2;
  localparam int          SCORE_W             = 16;

  typedef enum logic [2:0] {
    ST_MENU,
    ST_MENU_WAIT,
    ST_FRAME_WAIT,
    ST_ERASE,
    ST_PHYS,
    ST_SCROLL,
    ST_DRAW,
    ST_OVER
  } state_e;

  localparam logic [STEP_OP_W-1:0] OP_ERASE  = 2'd0;
  localparam logic [STEP_OP_W-1:0] OP_PHYS   = 2'd1;
  localparam logic [STEP_OP_W-1:0] OP_SCROLL = 2'd2;
  localparam logic [STEP_OP_W-1:0] OP_DRAW   = 2'd3;

  function automatic logic is_game_state(state_e s);
    return (s == ST_FRAME_WAIT) || (s == ST_ERASE) || (s == ST_PHYS) ||
           (s == ST_SCROLL) || (s == ST_DRAW);
  endfunction

  function automatic logic is_step_state(state_e s);
    return (s == ST_ERASE) || (s == ST_PHYS) || (s == ST_SCROLL) || (s == ST_DRAW);
  endfunction

  function automatic logic [STEP_OP_W-1:0] op_of(state_e s);
    logic [STEP_OP_W-1:0] op;
    op = '0;
    case (s)
      ST_ERASE:  op = OP_ERASE;
      ST_PHYS:   op = OP_PHYS;
      ST_SCROLL: op = OP_SCROLL;
      ST_DRAW:   op = OP_DRAW;
      default:   op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Step handshake between the sequencer (master) and the drawing datapath (slave).
interface game_sequencer_if;
  import game_sequencer_pkg::*;

  logic                 step_req;
  logic [STEP_OP_W-1:0] step_op;
  logic                 step_done;
  logic                 endgame;

  modport master (output step_req, output step_op, input step_done, input endgame);
  modport slave  (input step_req, input step_op, output step_done, output endgame);

endinterface

// File: rtl/game_sequencer_frame_ticker.sv
// Frame period counter with a one-deep pending-tick flag and a sticky
// overrun flag for ticks that arrive while one is still outstanding.
module frame_ticker
  import game_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic consume,
  output logic pending,
  output logic overrun
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(FRAME_TICKS - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              tick;

  always_comb begin
    tick      = enable && (cnt_q == LAST);
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    if (clear || !enable || tick) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;

    // A tick landing on the consume cycle re-arms pending rather than being lost.
    if (clear) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end else if (tick) begin
      pending_d = 1'b1;
      if (pending_q && !consume) overrun_d = 1'b1;
    end else if (consume) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/game_sequencer.sv
// Game control FSM: menu handshake on the go button, then one
// ERASE/PHYS/SCROLL/DRAW datapath sequence per frame tick until collision.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 grav,
  game_sequencer_if.master     dp,
  output logic                 startgame,
  output logic                 grav_frame,
  output logic [SCORE_W-1:0]   frame_count,
  output logic                 overrun
);

  state_e               state_q, state_d;
  logic                 go_q;
  logic                 go_rise;
  logic                 step_req_q, step_req_d;
  logic [STEP_OP_W-1:0] step_op_q, step_op_d;
  logic                 startgame_q, startgame_d;
  logic                 grav_frame_q, grav_frame_d;
  logic [SCORE_W-1:0]   frame_count_q, frame_count_d;
  logic                 pending;
  logic                 consume;
  logic                 clear;

  frame_ticker #(.FRAME_TICKS(FRAME_TICKS)) u_ticker (
    .clk     (clk),
    .reset   (reset),
    .enable  (startgame_q),
    .clear   (clear),
    .consume (consume),
    .pending (pending),
    .overrun (overrun)
  );

  always_comb begin
    go_rise       = go && !go_q;
    state_d       = state_q;
    consume       = 1'b0;
    clear         = 1'b0;
    grav_frame_d  = grav_frame_q;
    frame_count_d = frame_count_q;

    unique case (state_q)
      ST_MENU: begin
        if (go_rise) state_d = ST_MENU_WAIT;
      end
      ST_MENU_WAIT: begin
        if (!go) begin
          state_d       = ST_FRAME_WAIT;
          clear         = 1'b1;
          frame_count_d = '0;
        end
      end
      ST_FRAME_WAIT: begin
        if (pending) begin
          state_d      = ST_ERASE;
          consume      = 1'b1;
          grav_frame_d = grav;
        end
      end
      ST_ERASE: begin
        if (dp.step_done) state_d = ST_PHYS;
      end
      ST_PHYS: begin
        if (dp.step_done) state_d = dp.endgame ? ST_OVER : ST_SCROLL;
      end
      ST_SCROLL: begin
        if (dp.step_done) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (dp.step_done) begin
          state_d = ST_FRAME_WAIT;
          if (frame_count_q != {SCORE_W{1'b1}}) frame_count_d = frame_count_q + 1'b1;
        end
      end
      ST_OVER: begin
        if (go_rise) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    step_req_d  = is_step_state(state_d) && (state_d != state_q);
    step_op_d   = is_step_state(state_d) ? op_of(state_d) : '0;
    startgame_d = is_game_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_MENU;
      go_q          <= 1'b0;
      step_req_q    <= 1'b0;
      step_op_q     <= '0;
      startgame_q   <= 1'b0;
      grav_frame_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      go_q          <= go;
      step_req_q    <= step_req_d;
      step_op_q     <= step_op_d;
      startgame_q   <= startgame_d;
      grav_frame_q  <= grav_frame_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign dp.step_req  = step_req_q;
  assign dp.step_op   = step_op_q;
  assign startgame    = startgame_q;
  assign grav_frame   = grav_frame_q;
  assign frame_count  = frame_count_q;

endmodule
